// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel produces a registered 50% duty square wave whose half-period is
// set through a shared write port. New divisors wait in a pending register and
// only take effect at a half-period boundary, while the channel is disabled, or
// on a global sync, so a half-period on clk_out is never shortened.
module clk_div_multi #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 25,
  parameter int CH_W     = 1,
  parameter int DEF_HALF = 25000000
) (
  input  logic              clk_50Mhz,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  // A write is legal only with a non-zero half-period aimed at an existing channel.
  logic w_chInRange;
  logic w_accept;

  assign w_chInRange = (32'(cfg_ch) < N_CH);
  assign w_accept    = cfg_wr && (cfg_half != '0) && w_chInRange;

  // Acknowledge or reject every write strobe one cycle after it is seen.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= w_accept;
      cfg_err <= cfg_wr && !w_accept;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : gChannel
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_halfR;
    logic [CNT_W-1:0] r_halfP;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic             w_wrHere;
    logic             w_wrap;

    // The compare is unsigned and full width; r_halfR is never zero because
    // zero-length writes are rejected, so the subtraction cannot underflow.
    assign w_wrHere = w_accept && (cfg_ch == CH_W'(g));
    assign w_wrap   = (r_cnt == (r_halfR - CNT_W'(1)));

    // Per-channel counter, output toggle, rise tick and divisor hand-over.
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_halfR <= CNT_W'(DEF_HALF);
        r_halfP <= CNT_W'(DEF_HALF);
        r_pend  <= 1'b0;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
      end else if (sync) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
        r_pend <= 1'b0;
        if (w_wrHere) begin
          r_halfR <= cfg_half;
          r_halfP <= cfg_half;
        end else if (r_pend) begin
          r_halfR <= r_halfP;
        end
      end else begin
        if (!en[g]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          if (r_pend) begin
            r_halfR <= r_halfP;
          end
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
          if (r_pend) begin
            r_halfR <= r_halfP;
          end
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
        end

        if (w_wrHere) begin
          r_halfP <= cfg_half;
          r_pend  <= 1'b1;
        end else if (r_pend && (!en[g] || w_wrap)) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: the stimulus pushes the cycle numbers at
// which tick and cfg_ack/cfg_err pulses must appear; a negedge monitor pops
// and compares them as the DUT produces them.
module tb_clk_div_multi;

  localparam int N_CH     = 2;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;
  localparam int DEF_HALF = 4;

  typedef struct packed {
    logic        isErr;
    logic [31:0] cyc;
  } cfgEvt_t;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   en;
  logic              sync;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ack;
  logic              cfg_err;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;

  int      cyc = 0;
  int      nCompared = 0;
  int      nMismatched = 0;
  bit      monOn = 0;
  int      tickQ0[$];
  int      tickQ1[$];
  cfgEvt_t cfgQ[$];
  int      K;
  int      R;

  clk_div_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEF_HALF(DEF_HALF)
  ) dut (
    .clk_50Mhz(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
  );

  // Free-running 100 MHz bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so events can be located by cycle number.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one cycle of write/sync inputs, then return them to idle.
  task automatic applyStimulus(input logic wr, input int ch, input int half, input logic syncIn);
    cfg_wr   = wr;
    cfg_ch   = CH_W'(ch);
    cfg_half = CNT_W'(half);
    sync     = syncIn;
    @(posedge clk);
    #1;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_half = '0;
    sync     = 1'b0;
  endtask

  task automatic pushCfg(input logic isErr, input int at);
    cfgEvt_t e;
    e.isErr = isErr;
    e.cyc   = 32'(at);
    cfgQ.push_back(e);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, " tick0 left"}, tickQ0.size(), 0);
    checkOutput({tag, " tick1 left"}, tickQ1.size(), 0);
    checkOutput({tag, " cfg left"}, cfgQ.size(), 0);
    tickQ0.delete();
    tickQ1.delete();
    cfgQ.delete();
  endtask

  // Monitor: every observed pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (monOn) begin
      if (tick[0]) begin
        if (tickQ0.size() == 0) checkOutput("tick0 unexpected", cyc, -1);
        else checkOutput("tick0 cycle", cyc, tickQ0.pop_front());
      end
      if (tick[1]) begin
        if (tickQ1.size() == 0) checkOutput("tick1 unexpected", cyc, -1);
        else checkOutput("tick1 cycle", cyc, tickQ1.pop_front());
      end
      if (cfg_ack || cfg_err) begin
        if (cfgQ.size() == 0) begin
          checkOutput("cfg unexpected", cyc, -1);
        end else begin
          cfgEvt_t e;
          e = cfgQ.pop_front();
          checkOutput("cfg cycle", cyc, int'(e.cyc));
          checkOutput("cfg_err", int'(cfg_err), int'(e.isErr));
          checkOutput("cfg_ack", int'(cfg_ack), int'(!e.isErr));
        end
      end
    end
  end

  initial begin
    int ch0Rise[] = '{4, 12, 20, 28, 34, 38, 42, 48, 54, 60, 66, 72, 78, 86, 92, 98};
    int ch1Rise[] = '{4, 12, 20, 28, 36, 44, 50, 60, 70, 80};

    rst_n    = 1'b1;
    en       = '0;
    sync     = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_half = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset clk_out", int'(clk_out), 0);
    checkOutput("reset tick", int'(tick), 0);
    checkOutput("reset cfg_ack", int'(cfg_ack), 0);
    checkOutput("reset cfg_err", int'(cfg_err), 0);

    // Expected pulses, as offsets from the reset-release cycle K.
    K = 3;
    foreach (ch0Rise[i]) tickQ0.push_back(K + ch0Rise[i]);
    foreach (ch1Rise[i]) tickQ1.push_back(K + ch1Rise[i]);
    for (int c = 84; c <= 100; c += 2) tickQ1.push_back(K + c);
    pushCfg(1'b0, K + 30);
    pushCfg(1'b1, K + 38);
    pushCfg(1'b1, K + 40);
    pushCfg(1'b0, K + 42);
    pushCfg(1'b0, K + 43);
    pushCfg(1'b0, K + 82);
    pushCfg(1'b0, K + 101);

    // Release reset with both channels enabled at the default half-period of 4.
    waitCycle(K);
    en    = 2'b11;
    rst_n = 1'b1;
    monOn = 1'b1;
    waitCycle(K + 4);
    checkOutput("first rise level", int'(clk_out), 3);
    waitCycle(K + 8);
    checkOutput("first fall level", int'(clk_out), 0);

    // Ch0 half=2 written at cnt=1: the running high half still lasts 4 cycles.
    waitCycle(K + 29);
    applyStimulus(1'b1, 0, 2, 1'b0);
    waitCycle(K + 31);
    checkOutput("ch0 half not cut", int'(clk_out[0]), 1);
    waitCycle(K + 32);
    checkOutput("ch0 falls at 4", int'(clk_out[0]), 0);
    waitCycle(K + 34);
    checkOutput("ch0 new half 2", int'(clk_out[0]), 1);

    // Rejected writes: zero half-period, then a channel that does not exist.
    waitCycle(K + 37);
    applyStimulus(1'b1, 1, 0, 1'b0);
    waitCycle(K + 39);
    applyStimulus(1'b1, 3, 5, 1'b0);

    // Ch0 half=3, ch1 half=5, then sync mid-period.
    waitCycle(K + 41);
    applyStimulus(1'b1, 0, 3, 1'b0);
    applyStimulus(1'b1, 1, 5, 1'b0);
    waitCycle(K + 44);
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("sync clears clk_out", int'(clk_out), 0);
    waitCycle(K + 75);
    checkOutput("aligned at lcm", int'(clk_out), 0);
    waitCycle(K + 78);
    checkOutput("after lcm", int'(clk_out), 1);

    // Ch1 half=1 then sync: clk_out[1] toggles every cycle.
    waitCycle(K + 81);
    applyStimulus(1'b1, 1, 1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("sync2 clk_out", int'(clk_out), 0);
    waitCycle(K + 84);
    checkOutput("half1 high", int'(clk_out), 2);
    waitCycle(K + 85);
    checkOutput("half1 low", int'(clk_out), 0);

    // Pending write to ch0, then reset before it can transfer.
    waitCycle(K + 100);
    applyStimulus(1'b1, 0, 7, 1'b0);
    waitCycle(K + 102);
    monOn = 1'b0;
    checkDrained("run");
    rst_n = 1'b0;
    #1;
    checkOutput("async reset clk_out", int'(clk_out), 0);
    checkOutput("async reset tick", int'(tick), 0);

    // After release the period must again be 2*DEF_HALF on both channels.
    waitCycle(K + 104);
    R = K + 104;
    for (int c = 4; c <= 20; c += 8) begin
      tickQ0.push_back(R + c);
      tickQ1.push_back(R + c);
    end
    rst_n = 1'b1;
    monOn = 1'b1;
    waitCycle(R + 24);
    monOn = 1'b0;
    checkDrained("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
